seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply.
// Define ALU_SAT_EN to build the saturating ADD/SUB datapath (sat input); otherwise sat is ignored.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } alu_rsp_t;

    state_t             state;
    alu_rsp_t           rsp;
    logic [WIDTH:0]     ext;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shamt     = b[SW-1:0];

`ifndef ALU_SAT_EN
    logic sat_unused;
    assign sat_unused = sat;
`endif

    // Single-cycle ops evaluated straight from the inputs on the accepting edge.
    always_comb begin
        rsp = '0;
        ext = '0;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                rsp.res = ext[WIDTH-1:0];
                rsp.c   = ext[WIDTH];
                rsp.v   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (sat) begin
                    rsp.v = 1'b0;
                    if (rsp.c) rsp.res = '1;
                end
`endif
            end
            OP_SUB: begin
                ext     = {1'b0, a} - {1'b0, b};
                rsp.res = ext[WIDTH-1:0];
                rsp.c   = ext[WIDTH];
                rsp.v   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (sat) begin
                    rsp.v = 1'b0;
                    if (rsp.c) rsp.res = '0;
                end
`endif
            end
            OP_AND: rsp.res = a & b;
            OP_OR:  rsp.res = a | b;
            OP_XOR: rsp.res = a ^ b;
            // Extra bit beyond the operand catches the last bit shifted out.
            OP_SHL: begin
                ext     = {1'b0, a} << shamt;
                rsp.res = ext[WIDTH-1:0];
                rsp.c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext     = {a, 1'b0} >> shamt;
                rsp.res = ext[WIDTH:1];
                rsp.c   = ext[0];
            end
            default: ;
        endcase
    end

    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (op == OP_MUL) begin
                        state  <= BUSY;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                    end else begin
                        state    <= DONE;
                        result   <= rsp.res;
                        carry    <= rsp.c;
                        overflow <= rsp.v;
                        zero     <= (rsp.res == '0);
                        negative <= rsp.res[WIDTH-1];
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last multiplier bit folds in on the same edge that enters DONE.
                    if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        result   <= acc_nxt[WIDTH-1:0];
                        carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        zero     <= (acc_nxt[WIDTH-1:0] == '0);
                        negative <= acc_nxt[WIDTH-1];
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=8), plus handshake, throughput and reset sequences.
module tb_seq_alu;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sat = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, zero, carry, overflow, negative;
    logic [W-1:0] a = '0, b = '0, result;
    logic [2:0]   op = '0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       sat;
        logic [7:0] res;
        logic       c, v, z, n;
        int         lat;
    } vec_t;

    vec_t vt[18];

    // Present one operand set, scramble inputs after accept, wait (bounded) for out_valid.
    task automatic run_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input logic s, output logic [7:0] r, output logic [3:0] f, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        a = aa; b = bb; op = o; sat = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~aa; b = ~bb; op = o ^ 3'b101; sat = ~s;
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        r = result;
        f = {carry, overflow, zero, negative};
    endtask

    task automatic take_result(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " in_ready after take"}, in_ready, 1);
        chk({nm, " out_valid after take"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        int         lat, cnt;

        //        op    a      b      sat   res    c     v     z     n    lat
        vt[0]  = '{3'd0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[1]  = '{3'd0, 8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1, 1};
        vt[2]  = '{3'd1, 8'd5,   8'd5,   1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[3]  = '{3'd1, 8'd10,  8'd20,  1'b0, 8'd246, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[4]  = '{3'd2, 8'hF0,  8'h3C,  1'b0, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[5]  = '{3'd3, 8'h0F,  8'h80,  1'b0, 8'h8F,  1'b0, 1'b0, 1'b0, 1'b1, 1};
        vt[6]  = '{3'd4, 8'hAA,  8'hAA,  1'b0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[7]  = '{3'd5, 8'h81,  8'h01,  1'b0, 8'h02,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[8]  = '{3'd5, 8'h81,  8'h00,  1'b0, 8'h81,  1'b0, 1'b0, 1'b0, 1'b1, 1};
        vt[9]  = '{3'd6, 8'h81,  8'h01,  1'b0, 8'h40,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{3'd6, 8'hC0,  8'h0F,  1'b0, 8'h01,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[11] = '{3'd7, 8'd15,  8'd17,  1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 9};
        vt[12] = '{3'd7, 8'd16,  8'd16,  1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 9};
        vt[13] = '{3'd1, 8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1, 1'b0, 1'b0, 1};
`ifdef ALU_SAT_EN
        vt[14] = '{3'd0, 8'd200, 8'd100, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[15] = '{3'd1, 8'd10,  8'd20,  1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1};
        vt[16] = '{3'd0, 8'h7F,  8'h01,  1'b1, 8'h80,  1'b0, 1'b0, 1'b0, 1'b1, 1};
`else
        vt[14] = '{3'd0, 8'd200, 8'd100, 1'b1, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[15] = '{3'd1, 8'd10,  8'd20,  1'b1, 8'd246, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[16] = '{3'd0, 8'h7F,  8'h01,  1'b1, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1, 1};
`endif
        vt[17] = '{3'd7, 8'd255, 8'd255, 1'b0, 8'h01,  1'b1, 1'b0, 1'b0, 1'b0, 9};

        // Reset state, sampled mid-cycle while rst_n is low.
        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", {carry, overflow, zero, negative}, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sat, r, f, lat);
            chk($sformatf("v%0d result", i), r, vt[i].res);
            chk($sformatf("v%0d carry", i), f[3], vt[i].c);
            chk($sformatf("v%0d overflow", i), f[2], vt[i].v);
            chk($sformatf("v%0d zero", i), f[1], vt[i].z);
            chk($sformatf("v%0d negative", i), f[0], vt[i].n);
            chk($sformatf("v%0d latency", i), lat, vt[i].lat);
            take_result($sformatf("v%0d", i));
        end

        // Back-to-back ADDs with both handshakes held high: one result every 2 cycles.
        @(negedge clk);
        a = 8'd1; b = 8'd2; op = 3'd0; sat = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("throughput valid count", cnt, 5);
        chk("throughput result", result, 3);

        // Result held under back-pressure; new operands ignored while DONE.
        run_op(3'd0, 8'd200, 8'd100, 1'b0, r, f, lat);
        chk("hold initial result", r, 44);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'(k); b = 8'd3; op = 3'd1;
            @(posedge clk); #1;
            chk($sformatf("hold%0d result", k), result, 44);
            chk($sformatf("hold%0d carry", k), carry, 1);
            chk($sformatf("hold%0d out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d in_ready", k), in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take_result("hold");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        a = 8'd15; b = 8'd17; op = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mul busy in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset result", result, 0);
        chk("midreset carry", carry, 0);
        chk("midreset in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 8'd1, 8'd1, 1'b0, r, f, lat);
        chk("post-reset result", r, 2);
        chk("post-reset latency", lat, 1);
        chk("post-reset flags", f, 0);
        take_result("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
